// File: rtl/adder_operand_recovery.sv
// Recovers operand A = C - B from a registered adder's sum, flags results outside the WIDTH-bit range,
// and queues {A, ovf} in a small FIFO. One cycle of latency; in_ready drops only when the FIFO is full and the head is not being taken.
module adder_operand_recovery #(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 2,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   C,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] A,
   output logic             ovf,
   output logic [15:0]      op_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH+1:0] d;
   logic             range_err;
   logic [WIDTH-1:0] a_res;

   logic [WIDTH:0]   mem [DEPTH];
   logic [WIDTH:0]   last;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             push;
   logic             pop;

   // Both operands sign-extended to WIDTH+2 bits, so the difference cannot overflow.
   assign d = {C[WIDTH], C} - {{2{B[WIDTH-1]}}, B};

   // D fits in WIDTH signed bits exactly when its top three bits agree.
   assign range_err = ~((&d[WIDTH+1:WIDTH-1]) | ~(|d[WIDTH+1:WIDTH-1]));

   always_comb begin
      a_res = d[WIDTH-1:0];
      if (SATURATE && range_err) begin
         a_res = d[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   assign full      = (count == FULL_CNT);
   assign out_valid = (count != '0);
   assign in_ready  = reset & (~full | out_ready);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // When the FIFO drains, the outputs keep showing the last entry popped.
   assign A   = out_valid ? mem[rd_ptr][WIDTH:1] : last[WIDTH:1];
   assign ovf = out_valid ? mem[rd_ptr][0]       : last[0];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {a_res, range_err};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         last     <= '0;
         op_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            last     <= mem[rd_ptr];
            op_count <= op_count + 16'd1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adder_operand_recovery.sv
// Directed bench for adder_operand_recovery: wrap and saturate instances share one stimulus stream.
module tb_adder_operand_recovery;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       out_ready;
   logic [4:0] C;
   logic [3:0] B;

   logic       in_ready_w, out_valid_w, ovf_w;
   logic [3:0] a_w;
   logic [15:0] op_count_w;
   logic       in_ready_s, out_valid_s, ovf_s;
   logic [3:0] a_s;
   logic [15:0] op_count_s;

   int n_checks = 0;
   int n_fail   = 0;
   int base;

   adder_operand_recovery #(.WIDTH(4), .DEPTH(2), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
      .C(C), .B(B), .out_valid(out_valid_w), .out_ready(out_ready),
      .A(a_w), .ovf(ovf_w), .op_count(op_count_w)
   );

   adder_operand_recovery #(.WIDTH(4), .DEPTH(2), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
      .C(C), .B(B), .out_valid(out_valid_s), .out_ready(out_ready),
      .A(a_s), .ovf(ovf_s), .op_count(op_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push one vector, then check the new head on both instances.
   task automatic vec(input int c, input int b, input int ea, input int eo,
                      input int sa, input int so);
      in_valid = 1'b1;
      C = 5'(c);
      B = 4'(b);
      tick();
      in_valid = 1'b0;
      check("wrap_valid", int'(out_valid_w), 1);
      check("wrap_A", int'($signed(a_w)), ea);
      check("wrap_ovf", int'(ovf_w), eo);
      check("sat_A", int'($signed(a_s)), sa);
      check("sat_ovf", int'(ovf_s), so);
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      C         = 5'd5;
      B         = 4'd1;
      tick();
      check("rst_out_valid", int'(out_valid_w), 0);
      check("rst_A", int'(a_w), 0);
      check("rst_ovf", int'(ovf_w), 0);
      check("rst_op_count", int'(op_count_w), 0);
      check("rst_in_ready", int'(in_ready_w), 0);
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      check("rel_in_ready", int'(in_ready_w), 1);

      // Arithmetic: wrap vs. saturate results
      vec(7, 3, 4, 0, 4, 0);
      vec(-16, -8, -8, 0, -8, 0);
      vec(15, -8, 7, 1, 7, 1);
      vec(-16, 7, -7, 1, -8, 1);
      vec(-3, 2, -5, 0, -5, 0);
      tick();
      check("drain_valid", int'(out_valid_w), 0);
      check("drain_op_count", int'(op_count_w), 5);
      check("hold_A", int'($signed(a_w)), -5);
      check("sat_op_count", int'(op_count_s), 5);

      // Backpressure: two accepted, third refused, then ordered drain
      out_ready = 1'b0;
      in_valid  = 1'b1;
      C = 5'd1; B = 4'd0;
      tick();
      check("bp_A1", int'(a_w), 1);
      C = 5'd2;
      tick();
      C = 5'd3;
      #1;
      check("bp_in_ready", int'(in_ready_w), 0);
      tick();
      check("bp_hold_A", int'(a_w), 1);
      check("bp_valid", int'(out_valid_w), 1);
      out_ready = 1'b1;
      #1;
      check("bp_full_rdy", int'(in_ready_w), 1);
      tick();
      in_valid = 1'b0;
      check("bp_out2", int'(a_w), 2);
      tick();
      check("bp_out3", int'(a_w), 3);
      tick();
      check("bp_empty", int'(out_valid_w), 0);
      check("bp_op_count", int'(op_count_w), 8);

      // FULL streaming: one push and one pop each cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      C = 5'd4; tick();
      C = 5'd5; tick();
      base = int'(op_count_w);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         C = 5'(6 + i);
         #1;
         check("full_in_ready", int'(in_ready_w), 1);
         check("full_head", int'(a_w), 4 + i);
         tick();
      end
      check("full_op_count", int'(op_count_w), base + 10);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("full_still_full", int'(in_ready_w), 0);
      check("full_head_after", int'(a_w), 14);

      // Reset with two entries queued and out_ready high
      out_ready = 1'b1;
      reset     = 1'b0;
      tick();
      check("mid_rst_valid", int'(out_valid_w), 0);
      check("mid_rst_op_count", int'(op_count_w), 0);
      check("mid_rst_A", int'(a_w), 0);
      reset = 1'b1;
      tick();
      check("mid_rst_discard", int'(out_valid_w), 0);

      // op_count wrap: 65537 edges of streaming give 65536 pops
      in_valid = 1'b1;
      C = 5'd1; B = 4'd0;
      for (int i = 0; i < 65536; i++) begin
         tick();
      end
      check("wrap_pre", int'(op_count_w), 65535);
      tick();
      check("wrap_op_count", int'(op_count_w), 0);
      check("wrap_valid_end", int'(out_valid_w), 1);
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
